// File: rtl/capture_buffer.sv
// Trigger/capture stage: circular sample RAM with level-crossing trigger and an oldest-first pop port.
// Optional TRIG_HYSTERESIS_EN adds the trig_hyst_i port and a rearm-flag trigger.
module capture_buffer #(
   parameter int unsigned X_WIDTH    = 16,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  x_valid_i,
   input  logic [X_WIDTH-1:0]    x_i,
   input  logic                  arm_i,
   input  logic [X_WIDTH-1:0]    trig_level_i,
   input  logic                  trig_rising_i,
   input  logic [ADDR_WIDTH-1:0] pre_count_i,
   input  logic                  force_trig_i,
`ifdef TRIG_HYSTERESIS_EN
   input  logic [X_WIDTH-1:0]    trig_hyst_i,
`endif
   output logic                  armed_o,
   output logic                  triggered_o,
   output logic                  done_o,
   input  logic                  rd_en_i,
   output logic [X_WIDTH-1:0]    rd_data_o,
   output logic                  rd_valid_o,
   output logic                  rd_last_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  pre_q, pre_d;
   logic                   force_q, force_d;
   logic                   armed_q, armed_d;
   logic                   triggered_q, triggered_d;
   logic                   done_q, done_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   rd_last_q, rd_last_d;
   logic [X_WIDTH-1:0]     rd_data_q;

   logic                   we_c, re_c, hit_c;
   logic [ADDR_WIDTH-1:0]  ram_addr_c;
   logic [X_WIDTH-1:0]     mem [DEPTH];

`ifdef TRIG_HYSTERESIS_EN
   logic                   rearm_q, rearm_d;
   logic [X_WIDTH:0]       hi_sum_c;
   logic [X_WIDTH-1:0]     lo_thr_c, hi_thr_c;
   logic                   arm_cond_c;

   // Rearm thresholds saturate at the ends of the sample range
   always_comb begin
      hi_sum_c   = {1'b0, trig_level_i} + {1'b0, trig_hyst_i};
      lo_thr_c   = (trig_level_i >= trig_hyst_i) ? X_WIDTH'(trig_level_i - trig_hyst_i) : '0;
      hi_thr_c   = hi_sum_c[X_WIDTH] ? '1 : hi_sum_c[X_WIDTH-1:0];
      arm_cond_c = trig_rising_i ? (x_i < lo_thr_c) : (x_i > hi_thr_c);
      hit_c      = rearm_q && (trig_rising_i ? (x_i >= trig_level_i) : (x_i <= trig_level_i));
   end
`else
   logic [X_WIDTH-1:0]     prev_q, prev_d;
   logic                   prev_vld_q, prev_vld_d;

   // Edge test against the previous valid sample of this capture
   always_comb begin
      hit_c = prev_vld_q &&
              (trig_rising_i ? ((prev_q < trig_level_i) && (x_i >= trig_level_i))
                             : ((prev_q > trig_level_i) && (x_i <= trig_level_i)));
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         pre_q       <= '0;
         force_q     <= 1'b0;
         armed_q     <= 1'b0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_data_q   <= '0;
`ifdef TRIG_HYSTERESIS_EN
         rearm_q     <= 1'b0;
`else
         prev_q      <= '0;
         prev_vld_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         pre_q       <= pre_d;
         force_q     <= force_d;
         armed_q     <= armed_d;
         triggered_q <= triggered_d;
         done_q      <= done_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
         if (re_c) rd_data_q <= mem[ram_addr_c];
`ifdef TRIG_HYSTERESIS_EN
         rearm_q     <= rearm_d;
`else
         prev_q      <= prev_d;
         prev_vld_q  <= prev_vld_d;
`endif
      end
   end

   // Single-port RAM: writes only in PRE/WAIT/POST, reads only in DONE
   assign ram_addr_c = re_c ? rd_ptr_q : wr_ptr_q;

   always_ff @(posedge clk) begin
      if (we_c) mem[ram_addr_c] <= x_i;
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      pre_d      = pre_q;
      force_d    = force_q;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      we_c       = 1'b0;
      re_c       = 1'b0;
`ifdef TRIG_HYSTERESIS_EN
      rearm_d    = rearm_q;
`else
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm_i) begin
               pre_d   = pre_count_i;
               cnt_d   = '0;
               force_d = 1'b0;
               state_d = (pre_count_i == '0) ? S_WAIT : S_PRE;
`ifdef TRIG_HYSTERESIS_EN
               rearm_d = 1'b0;
`else
               prev_vld_d = 1'b0;
`endif
            end else if ((state_q == S_DONE) && rd_en_i) begin
               re_c       = 1'b1;
               rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
               cnt_d      = cnt_q + ADDR_WIDTH'(1);
               rd_valid_d = 1'b1;
               if (cnt_q == '1) begin
                  rd_last_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         S_PRE, S_WAIT: begin
            if ((state_q == S_WAIT) && force_trig_i) force_d = 1'b1;
            if (x_valid_i) begin
               we_c     = 1'b1;
               wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
`ifdef TRIG_HYSTERESIS_EN
               if (arm_cond_c) rearm_d = 1'b1;
`else
               prev_d     = x_i;
               prev_vld_d = 1'b1;
`endif
               if (state_q == S_PRE) begin
                  cnt_d = cnt_q + ADDR_WIDTH'(1);
                  if (cnt_d == pre_q) state_d = S_WAIT;
               end else if (hit_c || force_q || force_trig_i) begin
                  // Frame starts pre_q samples before the trigger address
                  rd_ptr_d = wr_ptr_q - pre_q;
                  cnt_d    = ~pre_q;
                  state_d  = (pre_q == '1) ? S_DONE : S_POST;
               end
            end
         end
         S_POST: begin
            if (x_valid_i) begin
               we_c     = 1'b1;
               wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
               cnt_d    = cnt_q - ADDR_WIDTH'(1);
               if (cnt_q == ADDR_WIDTH'(1)) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      armed_d     = (state_d == S_PRE)  || (state_d == S_WAIT);
      triggered_d = (state_d == S_POST) || (state_d == S_DONE);
      done_d      = (state_d == S_DONE);
   end

   assign armed_o     = armed_q;
   assign triggered_o = triggered_q;
   assign done_o      = done_q;
   assign rd_data_o   = rd_data_q;
   assign rd_valid_o  = rd_valid_q;
   assign rd_last_o   = rd_last_q;

endmodule
